// File: rtl/filereg_tonet.sv
// filereg_tonet: serializes one 64-bit register-file response into a
// two-flit NoC packet, MSB word first (header), LSB word second (tail).
//
// Ports:
//   clk_i               clock
//   rst_i               synchronous active-high reset
//   filereg_s_tvalid_i  response valid
//   filereg_s_tready_o  response accepted (combinational)
//   filereg_s_tdata_i   response, [63:32] MSB word, [31:0] LSB word
//   filereg_s_tlast_i   always 1 from the filereg; ignored
//   network_valid_o     flit valid (registered)
//   network_ready_i     network accepts flit
//   network_data_o      {flit, flit_type, broadcast, vn_id}, flit in MSBs
module filereg_tonet #(
    parameter int unsigned FileRegIfDataWidth             = 64,
    parameter int unsigned NetworkIfFlitWidth             = 64,
    parameter int unsigned NetworkIfFlitTypeWidth         = 2,
    parameter int unsigned NetworkIfBroadcastWidth        = 1,
    parameter int unsigned NetworkIfVirtualNetworkIdWidth = 2,
    parameter int unsigned VirtualNetworkId               = 0,
    parameter int unsigned FlitTypeHeader                 = 0,
    parameter int unsigned FlitTypeTail                   = 2,
    localparam int unsigned NetworkIfDataWidth = NetworkIfFlitWidth + NetworkIfFlitTypeWidth
                                               + NetworkIfBroadcastWidth
                                               + NetworkIfVirtualNetworkIdWidth
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          filereg_s_tvalid_i,
    output logic                          filereg_s_tready_o,
    input  logic [FileRegIfDataWidth-1:0] filereg_s_tdata_i,
    input  logic                          filereg_s_tlast_i,
    output logic                          network_valid_o,
    input  logic                          network_ready_i,
    output logic [NetworkIfDataWidth-1:0] network_data_o
);

    localparam int unsigned WordWidth = 32;

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] SEND_MSB = 2'd1;
    localparam logic [1:0] SEND_LSB = 2'd2;

    localparam logic [NetworkIfFlitTypeWidth-1:0] TypeHeader =
        NetworkIfFlitTypeWidth'(FlitTypeHeader);
    localparam logic [NetworkIfFlitTypeWidth-1:0] TypeTail =
        NetworkIfFlitTypeWidth'(FlitTypeTail);
    localparam logic [NetworkIfBroadcastWidth-1:0] BcastNone = '0;
    localparam logic [NetworkIfVirtualNetworkIdWidth-1:0] VnId =
        NetworkIfVirtualNetworkIdWidth'(VirtualNetworkId);

    logic [1:0]                    state_q, state_d;
    logic [FileRegIfDataWidth-1:0] hold_q, hold_d;
    logic                          valid_d;
    logic [NetworkIfDataWidth-1:0] data_q, data_d;
    logic [WordWidth-1:0]          word_d;
    logic [NetworkIfFlitTypeWidth-1:0] type_d;
    logic                          in_hs, net_hs;

    // tlast carries no information: every beat is a complete response
    logic unused_tlast;
    assign unused_tlast = filereg_s_tlast_i;

    // A new response can enter when idle, or when the tail flit leaves this cycle
    assign filereg_s_tready_o = !rst_i && ((state_q == IDLE) ||
                                           ((state_q == SEND_LSB) && network_ready_i));

    assign in_hs  = filereg_s_tvalid_i && filereg_s_tready_o;
    assign net_hs = network_valid_o && network_ready_i;

    // State register, holding register and registered flit outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q         <= IDLE;
            hold_q          <= '0;
            network_valid_o <= 1'b0;
            data_q          <= '0;
        end else begin
            state_q         <= state_d;
            hold_q          <= hold_d;
            network_valid_o <= valid_d;
            data_q          <= data_d;
        end
    end

    assign network_data_o = data_q;

    // Next state, next holding value and next flit contents
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        valid_d = 1'b0;
        word_d  = '0;
        type_d  = TypeHeader;
        data_d  = '0;

        case (state_q)
            IDLE: begin
                if (in_hs) begin
                    hold_d  = filereg_s_tdata_i;
                    state_d = SEND_MSB;
                end
            end
            SEND_MSB: begin
                if (net_hs) begin
                    state_d = SEND_LSB;
                end
            end
            SEND_LSB: begin
                if (net_hs) begin
                    if (in_hs) begin
                        hold_d  = filereg_s_tdata_i;
                        state_d = SEND_MSB;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_d == SEND_MSB) begin
            valid_d = 1'b1;
            word_d  = hold_d[63:32];
            type_d  = TypeHeader;
        end else if (state_d == SEND_LSB) begin
            valid_d = 1'b1;
            word_d  = hold_d[31:0];
            type_d  = TypeTail;
        end

        if (valid_d) begin
            data_d = {NetworkIfFlitWidth'(word_d), type_d, BcastNone, VnId};
        end
    end

endmodule

// File: tb/tb_filereg_tonet.sv
// Bench for filereg_tonet: directed scenarios plus randomized traffic,
// all flits checked by a scoreboard queue filled on accepted responses.
module tb_filereg_tonet;

    localparam int unsigned DW = 64 + 2 + 1 + 2;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          tvalid;
    logic          tready;
    logic [63:0]   tdata;
    logic          tlast;
    logic          nvalid;
    logic          nready;
    logic [DW-1:0] ndata;

    int total = 0;
    int bad   = 0;
    logic [DW-1:0] exp_q[$];

    always #5 clk_i = ~clk_i;

    filereg_tonet dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .filereg_s_tvalid_i (tvalid),
        .filereg_s_tready_o (tready),
        .filereg_s_tdata_i  (tdata),
        .filereg_s_tlast_i  (tlast),
        .network_valid_o    (nvalid),
        .network_ready_i    (nready),
        .network_data_o     (ndata)
    );

    // Expected flit: 32-bit word zero-extended, then type, broadcast=0, vn=0
    function automatic logic [DW-1:0] mk(input logic [31:0] w, input logic [1:0] t);
        return {32'h0, w, t, 1'b0, 2'b00};
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Reference: each accepted response becomes header(MSB) then tail(LSB)
    always @(negedge clk_i) begin
        if (!rst_i && tvalid && tready) begin
            exp_q.push_back(mk(tdata[63:32], 2'd0));
            exp_q.push_back(mk(tdata[31:0], 2'd2));
        end
    end

    // Reset discards any packet in flight
    always @(posedge clk_i) begin
        if (rst_i) exp_q.delete();
    end

    // Monitor: every presented flit must match the head of the queue
    always @(negedge clk_i) begin
        if (nvalid === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_flit actual=%h required=none", ndata);
            end else begin
                check("flit", ndata, exp_q[0]);
                if (nready && !rst_i) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        logic [63:0] a;
        logic        hs;
        int          n;
        int          cyc;

        rst_i  = 1'b1;
        tvalid = 1'b0;
        tdata  = '0;
        tlast  = 1'b1;
        nready = 1'b0;

        // Reset state
        step();
        @(negedge clk_i);
        check("rst_tready", DW'(tready), DW'(0));
        check("rst_valid", DW'(nvalid), DW'(0));
        check("rst_data", ndata, DW'(0));
        step();
        rst_i = 1'b0;
        @(negedge clk_i);
        check("idle_tready", DW'(tready), DW'(1));
        check("idle_valid", DW'(nvalid), DW'(0));

        // Single response, ready held high
        a = 64'h11223344_55667788;
        tvalid = 1'b1; tdata = a; nready = 1'b1;
        step();
        tvalid = 1'b0;
        @(negedge clk_i);
        check("t1_msb", ndata, mk(32'h11223344, 2'd0));
        check("t1_msb_valid", DW'(nvalid), DW'(1));
        step();
        @(negedge clk_i);
        check("t1_lsb", ndata, mk(32'h55667788, 2'd2));
        step();
        @(negedge clk_i);
        check("t1_done_valid", DW'(nvalid), DW'(0));

        // Back-to-back A then B
        tvalid = 1'b1; tdata = 64'hA0A0A0A0_A1A1A1A1;
        step();
        tdata = 64'hB0B0B0B0_B1B1B1B1;
        @(negedge clk_i);
        check("b2b_a_msb", ndata, mk(32'hA0A0A0A0, 2'd0));
        check("b2b_msb_tready", DW'(tready), DW'(0));
        step();
        @(negedge clk_i);
        check("b2b_a_lsb", ndata, mk(32'hA1A1A1A1, 2'd2));
        check("b2b_lsb_tready", DW'(tready), DW'(1));
        step();
        tvalid = 1'b0;
        @(negedge clk_i);
        check("b2b_b_msb", ndata, mk(32'hB0B0B0B0, 2'd0));
        step();
        @(negedge clk_i);
        check("b2b_b_lsb", ndata, mk(32'hB1B1B1B1, 2'd2));
        step();

        // Backpressure on the MSB flit
        nready = 1'b0; tvalid = 1'b1; tdata = 64'hC0C1C2C3_C4C5C6C7;
        step();
        tvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            check("bp_msb_hold", ndata, mk(32'hC0C1C2C3, 2'd0));
            check("bp_msb_tready", DW'(tready), DW'(0));
            step();
        end
        nready = 1'b1;
        @(negedge clk_i);
        check("bp_msb_4th", ndata, mk(32'hC0C1C2C3, 2'd0));
        check("bp_msb_tready4", DW'(tready), DW'(0));
        step();
        @(negedge clk_i);
        check("bp_lsb", ndata, mk(32'hC4C5C6C7, 2'd2));
        step();

        // Backpressure on the LSB flit with a new response pending
        tvalid = 1'b1; tdata = 64'hD0D0D0D0_D1D1D1D1;
        step();
        tdata = 64'hE0E0E0E0_E1E1E1E1;
        step();
        nready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            check("bpl_tready", DW'(tready), DW'(0));
            check("bpl_lsb_hold", ndata, mk(32'hD1D1D1D1, 2'd2));
            step();
        end
        nready = 1'b1;
        @(negedge clk_i);
        check("bpl_tready_rel", DW'(tready), DW'(1));
        step();
        tvalid = 1'b0;
        @(negedge clk_i);
        check("bpl_e_msb", ndata, mk(32'hE0E0E0E0, 2'd0));
        step();
        @(negedge clk_i);
        check("bpl_e_lsb", ndata, mk(32'hE1E1E1E1, 2'd2));
        step();

        // Reset while presenting the LSB flit
        tvalid = 1'b1; tdata = 64'hF0F0F0F0_F1F1F1F1;
        step();
        tvalid = 1'b0;
        step();
        nready = 1'b0; rst_i = 1'b1;
        @(negedge clk_i);
        check("rst_mid_tready", DW'(tready), DW'(0));
        step();
        rst_i = 1'b0;
        @(negedge clk_i);
        check("rst_mid_valid", DW'(nvalid), DW'(0));
        check("rst_mid_tready_after", DW'(tready), DW'(1));
        tvalid = 1'b1; tdata = 64'h12345678_9ABCDEF0; nready = 1'b1;
        step();
        tvalid = 1'b0;
        @(negedge clk_i);
        check("rst_next_msb", ndata, mk(32'h12345678, 2'd0));
        step();
        @(negedge clk_i);
        check("rst_next_lsb", ndata, mk(32'h9ABCDEF0, 2'd2));
        step();

        // Randomized traffic: 1000 responses with random ready/valid
        n = 0;
        cyc = 0;
        tvalid = 1'b0;
        while (n < 1000 && cyc < 20000) begin
            @(negedge clk_i);
            hs = tvalid && tready;
            if (hs) n++;
            step();
            cyc++;
            if (hs || !tvalid) begin
                tvalid = ($urandom_range(0, 3) != 0);
                tdata  = {$urandom(), $urandom()};
            end
            nready = ($urandom_range(0, 3) != 0);
        end
        total++;
        if (n < 1000) begin
            bad++;
            $display("FAIL random_accept_count actual=%0d required=1000", n);
        end
        tvalid = 1'b0;
        nready = 1'b1;
        for (int i = 0; i < 20 && (exp_q.size() != 0 || nvalid); i++) step();
        @(negedge clk_i);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain actual=%0d_pending required=0_pending", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/filereg_tonet.md
Name: filereg_tonet

Overview:
- Converts router register-file (filereg) responses into NoC packets. This is the return-path neighbour of the network-to-filereg request converter.
- Accepts one FileRegIfDataWidth-bit response on an AXI-Stream target interface and serializes it into a two-flit packet: MSB word first, LSB word second.
- Each flit is emitted on the packed network interface with flit type, broadcast and virtual-network fields filled in.
- Sits between the filereg response port and the network interface injection port.

Parameters:
- FileRegIfDataWidth, 64, width of the filereg response; must equal 64 (2 x 32-bit words).
- NetworkIfFlitWidth, 64, flit payload width; must be >= 32.
- NetworkIfFlitTypeWidth, 2, flit type field width.
- NetworkIfBroadcastWidth, 1, broadcast field width.
- NetworkIfVirtualNetworkIdWidth, 2, virtual network id field width.
- VirtualNetworkId, 0, constant VN id stamped on every flit.
- FlitTypeHeader, 0, type code for the first flit.
- FlitTypeTail, 2, type code for the second flit.
- NetworkIfDataWidth (localparam), sum of the four network widths.

Ports:
- clk_i  input  1  clock
- rst_i  input  1  synchronous active-high reset
- filereg_s_tvalid_i  input  1  response valid
- filereg_s_tready_o  output  1  response accepted
- filereg_s_tdata_i  input  FileRegIfDataWidth  response word, [63:32] MSB word, [31:0] LSB word
- filereg_s_tlast_i  input  1  always 1 from filereg; ignored
- network_valid_o  output  1  flit valid
- network_ready_i  input  1  network accepts flit
- network_data_o  output  NetworkIfDataWidth  packed {flit, flit_type, broadcast, vn_id}, flit in MSBs

Behaviour:
- One clock, clk_i. rst_i is synchronous and active-high.
- Reset values:
  - state = IDLE, network_valid_o = 0, holding register cleared to 0.
  - filereg_s_tready_o = 0 while rst_i = 1.
- States:
  - IDLE: no response held.
  - SEND_MSB: MSB flit presented.
  - SEND_LSB: LSB flit presented.
- filereg_s_tready_o is combinational:
  - 1 when (state = IDLE) or (state = SEND_LSB and network_ready_i = 1), and rst_i = 0.
- Input handshake (tvalid & tready):
  - capture filereg_s_tdata_i into the 64-bit holding register;
  - next state = SEND_MSB.
- State transitions:
  - IDLE: input handshake -> SEND_MSB; otherwise stay.
  - SEND_MSB: network handshake -> SEND_LSB; otherwise hold with all outputs stable.
  - SEND_LSB: network handshake with a simultaneous input handshake -> SEND_MSB (back-to-back, new data captured); network handshake alone -> IDLE; no handshake -> hold.
- network_valid_o = 1 exactly in SEND_MSB and SEND_LSB. It is registered and never depends on network_ready_i.
- Flit payload:
  - zero-extended 32-bit word: flit[31:0] = word, flit[NetworkIfFlitWidth-1:32] = 0;
  - SEND_MSB carries holding[63:32], SEND_LSB carries holding[31:0].
- Other flit fields:
  - flit_type = FlitTypeHeader in SEND_MSB, FlitTypeTail in SEND_LSB;
  - broadcast = 0;
  - vn_id = VirtualNetworkId.
- Latency: first flit valid on the cycle after the input handshake. Second flit valid on the cycle after the first flit's handshake.
- Throughput: with network_ready_i held at 1, one flit per cycle and one response every 2 cycles, with no bubble between packets.
- Backpressure: network_data_o and network_valid_o hold stable while valid = 1 and ready = 0. The holding register is never overwritten before the LSB flit handshake.
- filereg_s_tlast_i is not checked. Every beat is a complete response.
- Reset mid-packet: the packet is dropped, valid drops the next cycle, and no partial flit is ever re-emitted.

Test Plan:
- Single response, network_ready_i = 1:
  - stimulus: tdata = 0x11223344_55667788;
  - required: flits 0x...11223344 type 0 then 0x...55667788 type 2, on consecutive cycles starting one cycle after accept;
  - required: vn_id = VirtualNetworkId, broadcast = 0.
- Back-to-back responses A = 0xA0A0A0A0_A1A1A1A1 and B = 0xB0B0B0B0_B1B1B1B1, ready always 1:
  - required: 4 flits on 4 consecutive cycles;
  - required: tready high during A's LSB cycle, and B is captured there.
- Backpressure, network_ready_i = 0 for 3 cycles during the MSB flit, then 1:
  - required: MSB flit held stable for 4 cycles, then LSB flit sent;
  - required: tready = 0 throughout SEND_MSB.
- Backpressure on the LSB flit while a new tvalid is pending:
  - required: tready stays 0 until the LSB handshake;
  - required: the new response is accepted in the same cycle as that handshake, and the pending data is not corrupted.
- Reset asserted in SEND_LSB:
  - required: the next cycle shows valid = 0 and state IDLE;
  - required: after reset deassertion, tready = 1 and the next response is emitted fully with correct types.
- Random ready and tvalid stimulus over 1000 responses against a scoreboard:
  - required: flit order MSB/LSB preserved;
  - required: no loss or duplication;
  - required: type codes alternate header/tail.
